// File: rtl/memory_stage_pkg.sv
// Shared bus and pipeline types for the memory stage: the data-bus handshake
// structs (common) and the execute/memory pipeline bundles with op decode (pipes).
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

package pipes;

  typedef logic [4:0] creg_addr_t;

  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL,
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } op_t;

  typedef struct packed {
    op_t  op;
    logic regwrite;
  } ctl_t;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] rd2;
    ctl_t        ctl;
    creg_addr_t  dst;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
    logic        bubble;
    logic        ismem;
  } excute_data_t;

  typedef struct packed {
    logic [63:0] result;
    ctl_t        ctl;
    creg_addr_t  dst;
    logic [63:0] pc;
    logic [31:0] raw_instr;
    logic        valid;
    logic        bubble;
    logic        misalign;
  } memory_data_t;

  typedef enum logic {
    MS_IDLE,
    MS_WAIT
  } mem_state_t;

  function automatic logic op_is_load(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU};
  endfunction

  function automatic logic op_is_store(input op_t op);
    return op inside {OP_SB, OP_SH, OP_SW, OP_SD};
  endfunction

  function automatic logic op_sign_ext(input op_t op);
    return op inside {OP_LB, OP_LH, OP_LW};
  endfunction

  function automatic logic [2:0] op_msize(input op_t op);
    logic [2:0] size;
    case (op)
      OP_LB, OP_LBU, OP_SB: size = MSIZE1;
      OP_LH, OP_LHU, OP_SH: size = MSIZE2;
      OP_LW, OP_LWU, OP_SW: size = MSIZE4;
      default:              size = MSIZE8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/memory_stage_mem_format.sv
// Purely combinational byte-lane formatting: alignment check, store strobe/data
// placement and load extraction with sign or zero extension.
module mem_format
  import pipes::*;
(
  input  logic [2:0]  size,
  input  logic        sign_ext,
  input  logic [2:0]  off,
  input  logic [63:0] store_data,
  input  logic [63:0] bus_data,
  output logic        aligned,
  output logic [7:0]  strobe,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic [5:0]  shamt;
  logic [63:0] raw;
  logic [7:0]  mask;

  assign shamt = {off, 3'b000};
  assign raw   = bus_data >> shamt;
  assign wdata = store_data << shamt;

  // NOTE: every output of this block gets a default before the case so no path
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    mask      = 8'hFF;
    aligned   = (off == 3'd0);
    load_data = raw;
    case (size)
      MSIZE1: begin
        mask      = 8'h01;
        aligned   = 1'b1;
        load_data = {{56{sign_ext & raw[7]}}, raw[7:0]};
      end
      MSIZE2: begin
        mask      = 8'h03;
        aligned   = (off[0] == 1'b0);
        load_data = {{48{sign_ext & raw[15]}}, raw[15:0]};
      end
      MSIZE4: begin
        mask      = 8'h0F;
        aligned   = (off[1:0] == 2'b00);
        load_data = {{32{sign_ext & raw[31]}}, raw[31:0]};
      end
      default: ;
    endcase
  end

  assign strobe = mask << off;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues one data-bus request per load/store, freezes
// execute until data_ok, and registers the result bundle for writeback.
module memory_stage
  import common::*;
  import pipes::*;
#(
  parameter int WAIT_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  excute_data_t          dataE,
  output memory_data_t          dataM,
  output dbus_req_t             dreq,
  input  dbus_resp_t            dresp,
  output logic                  stop_formem,
  output logic [63:0]           rdM,
  output creg_addr_t            dstM,
  output logic                  ismemM,
  output logic                  bubbleM,
  output logic [WAIT_CNT_W-1:0] wait_cycles
);

  mem_state_t   state;
  logic         is_load;
  logic         is_store;
  logic         active;
  logic         aligned;
  logic         bus_req;
  logic         load_done;
  logic [2:0]   size;
  logic [7:0]   fmt_strobe;
  logic [63:0]  fmt_wdata;
  logic [63:0]  load_data;
  memory_data_t next_m;
  logic         unused_bits;

  assign is_load  = op_is_load(dataE.ctl.op);
  assign is_store = op_is_store(dataE.ctl.op);
  assign size     = op_msize(dataE.ctl.op);
  assign active   = dataE.ismem & ~dataE.bubble;

  mem_format u_format (
    .size       (size),
    .sign_ext   (op_sign_ext(dataE.ctl.op)),
    .off        (dataE.result[2:0]),
    .store_data (dataE.rd2),
    .bus_data   (dresp.data),
    .aligned    (aligned),
    .strobe     (fmt_strobe),
    .wdata      (fmt_wdata),
    .load_data  (load_data)
  );

  // Request is a pure function of dataE, which execute holds while we stall,
  // so the bus sees a stable request until data_ok without re-issue.
  assign bus_req     = active & aligned & reset_n;
  assign stop_formem = bus_req & ~dresp.data_ok;
  assign load_done   = bus_req & dresp.data_ok & is_load;

  always_comb begin
    dreq        = '0;
    dreq.valid  = bus_req;
    dreq.addr   = dataE.result;
    dreq.size   = size;
    dreq.strobe = is_store ? fmt_strobe : 8'h00;
    dreq.data   = is_store ? fmt_wdata : 64'h0;
  end

  assign rdM     = load_done ? load_data : dataE.result;
  assign dstM    = dataE.dst;
  assign ismemM  = dataE.ismem;
  assign bubbleM = dataE.bubble;

  always_comb begin
    next_m           = '0;
    next_m.result    = load_done ? load_data : dataE.result;
    next_m.ctl       = dataE.ctl;
    next_m.dst       = dataE.dst;
    next_m.pc        = dataE.pc;
    next_m.raw_instr = dataE.raw_instr;
    next_m.valid     = dataE.valid;
    next_m.bubble    = dataE.bubble;
    next_m.misalign  = active & ~aligned;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MS_IDLE;
    end else begin
      case (state)
        MS_IDLE: if (bus_req && !dresp.data_ok) state <= MS_WAIT;
        MS_WAIT: if (dresp.data_ok)             state <= MS_IDLE;
        default:                                state <= MS_IDLE;
      endcase
    end
  end

  // While stalled the old bundle stays but is marked a bubble so writeback
  // never commits it twice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dataM <= '0;
    end else if (!stop_formem) begin
      dataM <= next_m;
    end else begin
      dataM.bubble <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cycles <= '0;
    end else if (stop_formem && !(&wait_cycles)) begin
      wait_cycles <= wait_cycles + 1'b1;
    end
  end

  assign unused_bits = ^{dresp.addr_ok, state};

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer end of the execute→memory pipeline interface.
- Accepts the registered execute-stage bundle (excute_data_t) and performs loads and stores on the data bus (dbus).
- Drives stop_formem back to execute while a bus access is outstanding, and registers the result into memory_data_t for writeback.
- Exposes forwarding signals (rdM/dstM/ismemM/bubbleM) to the decode-stage bypass network.

Parameters:
- WAIT_CNT_W, 32, width of the saturating bus-wait performance counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- dataE  in  excute_data_t  execute bundle (result = address/ALU value, rd2 = store data, ctl, dst, pc, bubble, ismem)
- dataM  out  memory_data_t  registered memory-stage bundle to writeback
- dreq  out  dbus_req_t  {valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]}
- dresp  in  dbus_resp_t  {addr_ok, data_ok, data[63:0]}
- stop_formem  out  1  freeze execute register
- rdM  out  64  forwarding value (load data if load completes this cycle, else dataE.result)
- dstM  out  creg_addr_t  forwarding destination (dataE.dst)
- ismemM  out  1  dataE is a memory op (bypass must stall until data_ok)
- bubbleM  out  1  dataE.bubble
- wait_cycles  out  WAIT_CNT_W  total cycles spent with stop_formem high

Behaviour:
- Access kinds are decoded from dataE.ctl.op:
  - Loads: LB, LH, LW, LD, LBU, LHU, LWU.
  - Stores: SB, SH, SW, SD.
  - Access active = dataE.ismem & ~dataE.bubble.
- Address = dataE.result; off = addr[2:0].
- Size encoding: MSIZE1/2/4/8.
- Alignment rule: accesses must be naturally aligned.
  - A misaligned access issues no bus request and sets dataM.misalign=1.
  - A misaligned access completes in 1 cycle with no stall.
- Store formatting:
  - strobe = size mask << off (SB 0x01, SH 0x03, SW 0x0F, SD 0xFF before shift).
  - data = rd2 << (8*off).
- Load requests: strobe = 0.
- Load extraction: raw = dresp.data >> (8*off), truncated to size, then sign-extended, or zero-extended for the U variants.
- FSM states: IDLE, WAIT.
  - IDLE: if access active, aligned, and no data_ok this cycle → WAIT.
  - IDLE: if data_ok arrives in the same cycle (zero-wait bus) → stay IDLE and complete.
  - WAIT: data_ok → IDLE.
  - All other cases hold the current state.
- dreq.valid = access active & aligned & reset_n.
  - dreq.valid stays high, with addr/size/strobe/data stable, until the cycle data_ok is seen inclusive.
  - dreq.valid is combinational from dataE, which execute holds stable while stop_formem = 1.
- stop_formem = dreq.valid & ~dresp.data_ok.
  - On the data_ok cycle the stall drops, so execute advances on the same edge that dataM captures the result.
  - No request is ever re-issued for the same instruction.
- dataM update:
  - Registered on posedge when ~stop_formem.
  - While stalled, dataM holds the previous instruction with bubble = 1, so writeback sees a bubble and no double commit.
  - Fields copied from dataE: pc, dst, ctl, valid, raw instruction.
  - dataM.result = formatted load data for loads, else dataE.result.
  - dataM.bubble = dataE.bubble.
- Latency:
  - Non-memory op or misaligned access: 1 cycle.
  - Memory op: 1 + bus wait cycles.
- wait_cycles increments each cycle stop_formem = 1 and saturates at all-ones.
- Reset (asynchronous, at any time including mid-WAIT):
  - state = IDLE, dataM = '0, wait_cycles = 0.
  - dreq.valid is forced 0 immediately.
  - A data_ok arriving after reset release while in IDLE with no active access is ignored.

Decomposition:
- Shared package pipes:
  - memory_data_t (adds misalign bit).
  - Load/store op enum values.
  - MSIZE constants.
  - mem_state_t enum.
- Shared package common: dbus_req_t / dbus_resp_t.
- One sub-module, mem_format, holds the purely combinational store strobe/data shift and load extract/extend.
  - It is unit-testable on its own.
  - The FSM, stall logic and registers stay in memory_stage.

Test Plan:
- ADD bundle, result 0x42, dst x5, no ismem → dreq.valid=0, stop_formem=0, next cycle dataM.result=0x42, dst=5, bubble=0.
- SH addr 0x8000_0006, rd2 0x1234, data_ok after 3 cycles:
  - strobe 0xC0, data 0x1234_0000_0000_0000, dreq stable.
  - stop_formem high 3 cycles, wait_cycles=3.
  - dataM written once.
- LB addr 0x8000_0003, dresp.data 0x0000_0000_8000_0000 with zero-wait data_ok → dataM.result 0xFFFF_FFFF_FFFF_FF80. Same with LBU → 0x80.
- LW addr 0x8000_0002 (misaligned) → dreq.valid never asserted, no stall, dataM.misalign=1.
- reset_n pulsed low mid-WAIT of an LD → dreq.valid=0 the same cycle, dataM=0, state IDLE. A stray data_ok after release leaves dataM unchanged.
- Back-to-back LD x1 then ADD using x1:
  - ismemM=1 and rdM equals load data only in the data_ok cycle.
  - The ADD enters dataE exactly one cycle after data_ok.
